// File: rtl/i2c_host_buf.sv
// Host-side front end for an I2C master: one transaction descriptor, a TX FIFO feeding the
// master's data_in and an RX FIFO capturing received bytes, with status and sticky errors.
module i2c_host_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_wr_en,
  input  logic [7:0]    host_wr_data,
  input  logic          host_rd_en,
  output logic [7:0]    host_rd_data,
  input  logic [7:0]    cmd_addr_rw,
  input  logic [7:0]    cmd_len,
  input  logic          cmd_go,
  output logic          cmd_err,
  output logic          busy,
  output logic          done,
  output logic          short_xfer,
  output logic [AW:0]   tx_level,
  output logic [AW:0]   rx_level,
  output logic          tx_full,
  output logic          tx_empty,
  output logic          rx_full,
  output logic          rx_empty,
  output logic [2:0]    err_flags,
  input  logic          err_clr,
  output logic          i_ready,
  output logic [7:0]    data_addr_rw,
  output logic [7:0]    data_cnt,
  output logic [7:0]    data_in,
  input  logic          i_txff_rd,
  input  logic          i_rxff_wr,
  input  logic [7:0]    data_out,
  input  logic          i2c_done
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitDone, StFin} state_e;

  localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW:0]     tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic [7:0]      addr_rw_q, addr_rw_d, cnt_q, cnt_d, xfer_q, xfer_d;
  logic            short_q, short_d, cmd_err_q, cmd_err_d;
  logic [2:0]      err_q, err_d, err_new;
  logic            tx_pop_req, tx_pop, tx_push, rx_pop, rx_push;
  logic            go_ok, fin_short;

  assign tx_full  = (tx_lvl_q == LvlFull);
  assign tx_empty = (tx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == LvlFull);
  assign rx_empty = (rx_lvl_q == '0);
  assign tx_level = tx_lvl_q;
  assign rx_level = rx_lvl_q;

  // A read transaction still strobes i_txff_rd once; it must not consume TX data.
  assign tx_pop_req = i_txff_rd && !addr_rw_q[0];
  assign tx_pop     = tx_pop_req && !tx_empty;
  assign tx_push    = host_wr_en && (!tx_full || tx_pop);
  assign rx_pop     = host_rd_en && !rx_empty;
  assign rx_push    = i_rxff_wr && (!rx_full || rx_pop);
  assign err_new    = {i_rxff_wr && !rx_push, tx_pop_req && tx_empty, host_wr_en && !tx_push};

  assign data_in      = tx_empty ? 8'h00 : tx_mem[tx_rptr_q];
  assign host_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];

  always_comb begin
    tx_wptr_d = tx_wptr_q + AW'(tx_push);
    tx_rptr_d = tx_rptr_q + AW'(tx_pop);
    rx_wptr_d = rx_wptr_q + AW'(rx_push);
    rx_rptr_d = rx_rptr_q + AW'(rx_pop);
    tx_lvl_d  = tx_lvl_q;
    rx_lvl_d  = rx_lvl_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_lvl_d = tx_lvl_q + 1'b1;
      2'b01:   tx_lvl_d = tx_lvl_q - 1'b1;
      default: tx_lvl_d = tx_lvl_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_lvl_d = rx_lvl_q + 1'b1;
      2'b01:   rx_lvl_d = rx_lvl_q - 1'b1;
      default: rx_lvl_d = rx_lvl_q;
    endcase
    err_d = err_clr ? 3'b000 : (err_q | err_new);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= host_wr_data;
    if (rx_push) rx_mem[rx_wptr_q] <= data_out;
  end

  assign go_ok = (cmd_len != 8'd0) &&
                 (cmd_addr_rw[0] || (32'(tx_lvl_q) >= 32'(cmd_len)));
  assign fin_short = (xfer_q != (cnt_q + 8'd1));

  always_comb begin
    state_d   = state_q;
    addr_rw_d = addr_rw_q;
    cnt_d     = cnt_q;
    short_d   = short_q;
    cmd_err_d = 1'b0;
    xfer_d    = xfer_q + 8'(addr_rw_q[0] ? i_rxff_wr : tx_pop);
    case (state_q)
      StIdle: begin
        if (cmd_go) begin
          if (go_ok) begin
            addr_rw_d = cmd_addr_rw;
            cnt_d     = cmd_len - 8'd1;
            xfer_d    = 8'd0;
            short_d   = 1'b0;
            state_d   = StReq;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (i2c_done)       state_d = StFin;
        else if (i_txff_rd) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i2c_done) state_d = StFin;
      end
      StFin: begin
        short_d = fin_short;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign i_ready      = (state_q == StReq);
  assign busy         = (state_q == StReq) || (state_q == StWaitDone);
  assign done         = (state_q == StFin);
  // Expose the outcome during the done pulse as well as afterwards.
  assign short_xfer   = (state_q == StFin) ? fin_short : short_q;
  assign cmd_err      = cmd_err_q;
  assign err_flags    = err_q;
  assign data_addr_rw = addr_rw_q;
  assign data_cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_lvl_q  <= '0;
      rx_lvl_q  <= '0;
      addr_rw_q <= 8'd0;
      cnt_q     <= 8'd0;
      xfer_q    <= 8'd0;
      short_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      err_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_lvl_q  <= tx_lvl_d;
      rx_lvl_q  <= rx_lvl_d;
      addr_rw_q <= addr_rw_d;
      cnt_q     <= cnt_d;
      xfer_q    <= xfer_d;
      short_q   <= short_d;
      cmd_err_q <= cmd_err_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_host_buf.sv
// Scenario bench for i2c_host_buf: the bench plays both host and I2C master, queueing expected
// bytes when they are written and comparing them when the DUT presents them.
module tb_i2c_host_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_wr_en = 1'b0, host_rd_en = 1'b0, cmd_go = 1'b0, err_clr = 1'b0;
  logic [7:0] host_wr_data = 8'h00, cmd_addr_rw = 8'h00, cmd_len = 8'h00, data_out = 8'h00;
  logic       i_txff_rd = 1'b0, i_rxff_wr = 1'b0, i2c_done = 1'b0;
  logic [7:0] host_rd_data, data_addr_rw, data_cnt, data_in;
  logic       cmd_err, busy, done, short_xfer, tx_full, tx_empty, rx_full, rx_empty, i_ready;
  logic [4:0] tx_level, rx_level;
  logic [2:0] err_flags;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] e;

  i2c_host_buf #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data),
    .cmd_addr_rw(cmd_addr_rw), .cmd_len(cmd_len), .cmd_go(cmd_go), .cmd_err(cmd_err),
    .busy(busy), .done(done), .short_xfer(short_xfer),
    .tx_level(tx_level), .rx_level(rx_level),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .err_flags(err_flags), .err_clr(err_clr),
    .i_ready(i_ready), .data_addr_rw(data_addr_rw), .data_cnt(data_cnt), .data_in(data_in),
    .i_txff_rd(i_txff_rd), .i_rxff_wr(i_rxff_wr), .data_out(data_out), .i2c_done(i2c_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
  endtask

  task automatic push_tx(input logic [7:0] b);
    host_wr_en = 1'b1;
    host_wr_data = b;
    if (exp_tx.size() < 16) exp_tx.push_back(b);
    step();
    host_wr_en = 1'b0;
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] n);
    cmd_addr_rw = a;
    cmd_len = n;
    cmd_go = 1'b1;
    step();
    cmd_go = 1'b0;
  endtask

  task automatic master_pop_check(input string tag);
    e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
    n_chk++;
    if (data_in !== e) begin
      n_fail++;
      $display("FAIL %s data_in: got %h expected %h", tag, data_in, e);
    end
    i_txff_rd = 1'b1;
    step();
    i_txff_rd = 1'b0;
  endtask

  task automatic host_read_check(input string tag);
    e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
    n_chk++;
    if (host_rd_data !== e) begin
      n_fail++;
      $display("FAIL %s host_rd_data: got %h expected %h", tag, host_rd_data, e);
    end
    host_rd_en = 1'b1;
    step();
    host_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({i_ready, busy, done, cmd_err, short_xfer, tx_full, tx_empty, rx_full, rx_empty}
        !== 9'b0_0000_0101) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000101",
               {i_ready, busy, done, cmd_err, short_xfer, tx_full, tx_empty, rx_full, rx_empty});
    end
    n_chk++;
    if ({tx_level, rx_level, err_flags, data_addr_rw, data_cnt, data_in, host_rd_data}
        !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_values: lvl %0d/%0d err %b addr %h cnt %h din %h rd %h expected 0",
               tx_level, rx_level, err_flags, data_addr_rw, data_cnt, data_in, host_rd_data);
    end
  endtask

  task automatic test_write3();
    apply_reset();
    push_tx(8'hA1);
    push_tx(8'hB2);
    push_tx(8'hC3);
    go(8'h50, 8'd3);
    n_chk++;
    if ({i_ready, busy, data_cnt, data_addr_rw} !== {2'b11, 8'd2, 8'h50}) begin
      n_fail++;
      $display("FAIL wr3_start: ready %b busy %b cnt %h addr %h expected 1 1 02 50",
               i_ready, busy, data_cnt, data_addr_rw);
    end
    master_pop_check("wr3_pop0");
    n_chk++;
    if (i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr3_ready_drop: got %b expected 0", i_ready);
    end
    master_pop_check("wr3_pop1");
    master_pop_check("wr3_pop2");
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    n_chk++;
    if ({done, short_xfer, busy, tx_empty} !== 4'b1001) begin
      n_fail++;
      $display("FAIL wr3_fin: done %b short %b busy %b tx_empty %b expected 1 0 0 1",
               done, short_xfer, busy, tx_empty);
    end
    step();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL wr3_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_read2();
    go(8'hA1, 8'd2);
    n_chk++;
    if ({i_ready, data_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL rd2_start: ready %b cnt %h expected 1 01", i_ready, data_cnt);
    end
    i_txff_rd = 1'b1;
    step();
    i_txff_rd = 1'b0;
    n_chk++;
    if ({tx_level, err_flags, i_ready} !== {5'd0, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL rd2_ignored_pop: lvl %0d err %b ready %b expected 0 000 0",
               tx_level, err_flags, i_ready);
    end
    for (int i = 0; i < 2; i++) begin
      data_out = (i == 0) ? 8'h5A : 8'h6B;
      exp_rx.push_back(data_out);
      i_rxff_wr = 1'b1;
      step();
      i_rxff_wr = 1'b0;
    end
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    n_chk++;
    if ({done, short_xfer, rx_level} !== {2'b10, 5'd2}) begin
      n_fail++;
      $display("FAIL rd2_fin: done %b short %b rx_level %0d expected 1 0 2",
               done, short_xfer, rx_level);
    end
    step();
    host_read_check("rd2_byte0");
    host_read_check("rd2_byte1");
    n_chk++;
    if ({rx_empty, host_rd_data} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL rd2_drained: rx_empty %b rd %h expected 1 00", rx_empty, host_rd_data);
    end
  endtask

  task automatic test_rejects();
    apply_reset();
    go(8'h50, 8'd0);
    n_chk++;
    if ({cmd_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL rej_len0: cmd_err %b busy %b expected 1 0", cmd_err, busy);
    end
    step();
    n_chk++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rej_pulse: cmd_err %b expected 0", cmd_err);
    end
    push_tx(8'h11);
    push_tx(8'h22);
    go(8'h50, 8'd4);
    n_chk++;
    if ({cmd_err, busy, tx_level} !== {2'b10, 5'd2}) begin
      n_fail++;
      $display("FAIL rej_short_tx: cmd_err %b busy %b lvl %0d expected 1 0 2",
               cmd_err, busy, tx_level);
    end
    go(8'hA1, 8'd1);
    go(8'h52, 8'd0);
    n_chk++;
    if ({cmd_err, busy, data_addr_rw, data_cnt} !== {2'b01, 8'hA1, 8'd0}) begin
      n_fail++;
      $display("FAIL rej_busy_go: cmd_err %b busy %b addr %h cnt %h expected 0 1 a1 00",
               cmd_err, busy, data_addr_rw, data_cnt);
    end
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    n_chk++;
    if ({done, short_xfer} !== 2'b11) begin
      n_fail++;
      $display("FAIL rej_noxfer_fin: done %b short %b expected 1 1", done, short_xfer);
    end
    step();
  endtask

  task automatic test_nack();
    apply_reset();
    push_tx(8'h31);
    push_tx(8'h32);
    push_tx(8'h33);
    go(8'h50, 8'd3);
    master_pop_check("nack_pop0");
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    n_chk++;
    if ({done, short_xfer, tx_level} !== {2'b11, 5'd2}) begin
      n_fail++;
      $display("FAIL nack_fin: done %b short %b lvl %0d expected 1 1 2",
               done, short_xfer, tx_level);
    end
    step();
    n_chk++;
    if ({done, short_xfer, data_in} !== {2'b01, 8'h32}) begin
      n_fail++;
      $display("FAIL nack_hold: done %b short %b din %h expected 0 1 32",
               done, short_xfer, data_in);
    end
  endtask

  task automatic test_tx_boundary();
    apply_reset();
    for (int i = 0; i < 17; i++) push_tx(8'(8'h80 + i));
    n_chk++;
    if ({tx_full, tx_level, err_flags} !== {1'b1, 5'd16, 3'b001}) begin
      n_fail++;
      $display("FAIL tx_ovf: full %b lvl %0d err %b expected 1 16 001",
               tx_full, tx_level, err_flags);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++;
    if (err_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL err_clr: got %b expected 000", err_flags);
    end
    go(8'h50, 8'd16);
    host_wr_en = 1'b1;
    host_wr_data = 8'h77;
    master_pop_check("full_pushpop");
    host_wr_en = 1'b0;
    exp_tx.push_back(8'h77);
    n_chk++;
    if ({tx_full, tx_level, err_flags} !== {1'b1, 5'd16, 3'b000}) begin
      n_fail++;
      $display("FAIL full_pushpop_lvl: full %b lvl %0d err %b expected 1 16 000",
               tx_full, tx_level, err_flags);
    end
    for (int i = 0; i < 16; i++) master_pop_check("drain");
    master_pop_check("empty_pop");
    n_chk++;
    if ({tx_empty, err_flags, data_in} !== {1'b1, 3'b010, 8'h00}) begin
      n_fail++;
      $display("FAIL tx_unf: empty %b err %b din %h expected 1 010 00",
               tx_empty, err_flags, data_in);
    end
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    step();
  endtask

  task automatic test_rx_overflow();
    apply_reset();
    go(8'hA1, 8'd17);
    for (int i = 0; i < 17; i++) begin
      data_out = 8'(8'h10 + i);
      if (exp_rx.size() < 16) exp_rx.push_back(data_out);
      i_rxff_wr = 1'b1;
      step();
      i_rxff_wr = 1'b0;
    end
    n_chk++;
    if ({rx_full, rx_level, err_flags} !== {1'b1, 5'd16, 3'b100}) begin
      n_fail++;
      $display("FAIL rx_ovf: full %b lvl %0d err %b expected 1 16 100",
               rx_full, rx_level, err_flags);
    end
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    step();
    for (int i = 0; i < 16; i++) host_read_check("rx_drain");
    host_read_check("rx_empty_pop");
    n_chk++;
    if ({rx_empty, rx_level} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL rx_after_drain: empty %b lvl %0d expected 1 0", rx_empty, rx_level);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) push_tx(8'(8'hC0 + i));
    go(8'h50, 8'd5);
    master_pop_check("mid_pop0");
    n_chk++;
    if ({busy, i_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_wait_state: busy %b ready %b expected 1 0", busy, i_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({i_ready, busy, tx_level, err_flags, tx_empty} !== {2'b00, 5'd0, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: ready %b busy %b lvl %0d err %b empty %b expected 0 0 0 000 1",
               i_ready, busy, tx_level, err_flags, tx_empty);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_write3();
    test_read2();
    test_rejects();
    test_nack();
    test_tx_boundary();
    test_rx_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
